// File: rtl/addsub_pipe_if.sv
// Operand/result bundle for addsub_pipe: operand beat in, result beat out.
// No storage of its own; timing is set entirely by the attached pipeline.
// in_valid/in_ready carry input backpressure; out_valid/out_ready carry output backpressure.
interface addsub_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
    logic             z;
    logic             n;

    // Upstream/downstream side: supplies operands and consumes results.
    modport master (
        output in_valid, a, b, m, out_ready,
        input  in_ready, out_valid, s, c, v, z, n
    );

    // Arithmetic block side.
    modport slave (
        input  in_valid, a, b, m, out_ready,
        output in_ready, out_valid, s, c, v, z, n
    );
endinterface

// File: rtl/addsub_pipe.sv
// Pipelined WIDTH-bit two's-complement add/sub (m=1: A-B) with c/v/z/n flags; ADDSUB_SAT_EN enables signed saturation.
// Latency STAGES cycles from the accepting edge; one beat per cycle when not stalled.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready combinationally.
module addsub_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    addsub_pipe_if.slave  bus
);
    // Each stage resolves one slice of the carry chain; WIDTH must divide evenly.
    localparam int SL = WIDTH / STAGES;

    // Everything a beat needs travels together: operands for the slices still
    // to come, its own mode bit, the partial sum so far and the running carry.
    typedef struct packed {
        logic             vld;
        logic             md;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
        logic             cy;
    } stage_t;

    logic   stall;
    logic   advance;
    stage_t last_q;

    assign stall        = last_q.vld & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t        src;
        stage_t        nxt;
        stage_t        q;
        logic [SL:0]   slice_sum;

        if (k == 0) begin : g_first
            // First stage takes the beat straight from the port; carry-in is the mode bit.
            always_comb begin
                src     = '0;
                src.vld = bus.in_valid;
                src.md  = bus.m;
                src.a   = bus.a;
                src.b   = bus.b;
                src.cy  = bus.m;
            end
        end else begin : g_later
            assign src = g_stage[k-1].q;
        end

        // B is inverted with this beat's own mode so mixed modes stay independent.
        assign slice_sum = {1'b0, src.a[k*SL +: SL]}
                         + {1'b0, src.b[k*SL +: SL] ^ {SL{src.md}}}
                         + {{SL{1'b0}}, src.cy};

        // Merge this slice's sum and carry into the beat moving forward.
        always_comb begin
            nxt                  = src;
            nxt.sum[k*SL +: SL]  = slice_sum[SL-1:0];
            nxt.cy               = slice_sum[SL];
        end

        // Stage register: advances together with every other stage, holds on stall.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (advance) begin
                q <= nxt;
            end
        end
    end

    assign last_q = g_stage[STAGES-1].q;

    logic             a_msb;
    logic             bx_msb;
    logic             ovf;
    logic [WIDTH-1:0] res;

    assign a_msb  = last_q.a[WIDTH-1];
    assign bx_msb = last_q.b[WIDTH-1] ^ last_q.md;

    // Overflow when both effective operands share a sign the result does not;
    // equivalent to carry-into-MSB XOR carry-out-of-MSB.
    always_comb begin
        ovf = (a_msb == bx_msb) && (last_q.sum[WIDTH-1] != a_msb);
`ifdef ADDSUB_SAT_EN
        // On overflow the true result has A's sign, so clamp toward it.
        res = ovf ? {a_msb, {(WIDTH-1){~a_msb}}} : last_q.sum;
`else
        res = last_q.sum;
`endif
    end

    assign bus.out_valid = last_q.vld;
    assign bus.s         = res;
    assign bus.c         = last_q.cy;
    assign bus.v         = ovf;
    // Qualified with valid so the idle/reset state reports z = 0.
    assign bus.z         = last_q.vld & (res == '0);
    assign bus.n         = res[WIDTH-1];

    // Only the operand sign bits matter once the last slice is done.
    logic unused_operand_bits;
    assign unused_operand_bits = ^{last_q.a[WIDTH-2:0], last_q.b[WIDTH-2:0]};
endmodule
